sram_bank_arbiter: RTL and testbench
====================================

// Module: sram_bank_arbiter
// PURPOSE
//  Shares the NUM_SRAMS scratchpad banks among NUM_REQ requesters (GEMM1, GEMM2, ELEM, AXI in/out).
//  Arbitrates round-robin per bank with a valid/ready handshake, so a bank conflict stalls the loser
//  instead of being silently merged. Drives the flattened en/we/addr/data_in bus of multi_sram and
//  routes each bank's read data back to the requester that issued the read.
// PARAMETERS
//  NUM_REQ       4   number of requesters; index 0 = GEMM1, 1 = GEMM2, 2 = ELEM, 3 = AXI
//  NUM_SRAMS     4   number of banks in multi_sram
//  BANK_W        2   width of a bank index, $clog2(NUM_SRAMS)
//  ADDR_WIDTH    16  word address width per bank
//  DATA_WIDTH    16  bank word width
//  SRAM_LATENCY  1   cycles from en to valid data_out; legal range 1..4
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     reset, synchronous, active-high
//  req_valid  in   NUM_REQ               request pending, one bit per requester
//  req_ready  out  NUM_REQ               grant; a request is accepted when valid & ready
//  req_we     in   NUM_REQ               1 = write, 0 = read
//  req_bank   in   NUM_REQ*BANK_W        target bank, one field per requester
//  req_addr   in   NUM_REQ*ADDR_WIDTH    word address, one field per requester
//  req_wdata  in   NUM_REQ*DATA_WIDTH    write data, one field per requester
//  rsp_valid  out  NUM_REQ               read data valid, one-cycle pulse
//  rsp_data   out  NUM_REQ*DATA_WIDTH    read data; 0 when the matching rsp_valid is 0
//  bank_err   out  1                     sticky; set on any request to bank >= NUM_SRAMS
//  sram_en    out  NUM_SRAMS             multi_sram en
//  sram_we    out  NUM_SRAMS             multi_sram we
//  sram_addr  out  NUM_SRAMS*ADDR_WIDTH  multi_sram addr
//  sram_wdata out  NUM_SRAMS*DATA_WIDTH  multi_sram data_in
//  sram_rdata in   NUM_SRAMS*DATA_WIDTH  multi_sram data_out
// BEHAVIOUR
//  Reset (rst=1 at a clk edge)
//   - Clears all rr_ptr[b], the response pipeline and bank_err.
//   - While rst=1: req_ready, sram_en, sram_we, rsp_valid = 0; sram_addr and sram_wdata = 0.
//  Arbitration (combinational, same cycle)
//   - For each bank b, candidates are requesters r with req_valid[r] and req_bank[r]==b.
//   - Winner is the first candidate scanning r = rr_ptr[b], rr_ptr[b]+1, ... mod NUM_REQ.
//   - Winner gets req_ready=1 and drives sram_en[b]=1, sram_we[b]=req_we, and the addr/wdata fields
//     of bank b. Losers get req_ready=0. Banks with no winner: en=we=0, addr/wdata=0.
//   - A requester targets one bank per cycle, so different banks are granted in parallel.
//   - On a grant at bank b, the next clk edge sets rr_ptr[b] = winner+1 mod NUM_REQ.
//     Banks with no grant keep their pointer.
//   - Starvation bound: a held request is granted within NUM_REQ cycles.
//  Requester rules
//   - Once asserted, req_valid and the request fields stay stable until accepted.
//   - The bench asserts this rule; the block does not check it.
//  Read response
//   - An accepted read enters a SRAM_LATENCY-deep pipeline carrying {valid, requester id, bank}.
//   - rsp_valid[id] pulses exactly SRAM_LATENCY cycles after acceptance.
//   - In that cycle rsp_data[id] = sram_rdata slice of that bank.
//   - Writes produce no response. Back-to-back reads give back-to-back pulses; throughput is 1 per bank per cycle.
//  Out-of-range bank (req_bank >= NUM_SRAMS)
//   - Accepted immediately with req_ready=1 and no SRAM access; bank_err is set on the next edge.
//   - A read still returns rsp_valid after SRAM_LATENCY with rsp_data=0, so requesters never hang.
//   - Out-of-range requests do not compete with in-range requests.
//  Reset mid-operation
//   - In-flight reads are discarded; no rsp_valid is produced for them.
//   - Partially issued writes complete or not according to multi_sram; no retry.
//  Bank write collision
//   - Same-bank, same-cycle collisions cannot occur: at most one grant per bank per cycle.
// TESTING
//  1. Single read: after reset, ELEM reads bank 1 addr 0x0010 holding 0x1234
//     -> req_ready[2]=1 same cycle; rsp_valid[2]=1 and rsp_data[2]=0x1234 exactly 1 cycle later.
//  2. Round-robin conflict: GEMM1, GEMM2, ELEM, AXI all hold valid on bank 0 for 4 cycles
//     -> grants in order 0,1,2,3, one per cycle; rr_ptr[0]=0 after the 4th grant.
//  3. Parallel banks: GEMM1 writes 0x00AA to bank 0 while GEMM2 writes 0x00BB to bank 2
//     -> both ready in the same cycle; read-back returns 0x00AA and 0x00BB.
//  4. Out-of-range bank: NUM_SRAMS=3, AXI reads bank 3
//     -> ready=1, no sram_en asserted, rsp_valid[3] with data 0 after latency, bank_err=1 until rst.
//  5. Reset mid-read: rst asserted the cycle after a read is accepted (SRAM_LATENCY=2)
//     -> no rsp_valid afterwards; all rr_ptr = 0.
//  6. Latency sweep: SRAM_LATENCY = 1, 2, 4 with 8 back-to-back reads from one requester
//     -> 8 consecutive rsp_valid pulses, in order, each matching the written data.

Source files
------------

// File: rtl/sram_bank_arbiter_if.sv
// Bundle between the requesters/multi_sram side (master) and the bank arbiter (slave).
// dbg_rr_ptr exposes the per-bank round-robin pointers so checkers can observe arbitration state.
interface sram_bank_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SRAMS  = 4,
    parameter int BANK_W     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    // Handshake: a request is accepted in the cycle where req_valid[r] && req_ready[r];
    // the requester holds valid and all request fields stable until that cycle.
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              req_we;
    logic [NUM_REQ*BANK_W-1:0]       req_bank;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_data;
    logic                            bank_err;
    logic [NUM_SRAMS-1:0]            sram_en;
    logic [NUM_SRAMS-1:0]            sram_we;
    logic [NUM_SRAMS*ADDR_WIDTH-1:0] sram_addr;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_wdata;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_rdata;
    logic [NUM_SRAMS*PTR_W-1:0]      dbg_rr_ptr;

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata, sram_rdata,
        input  req_ready, rsp_valid, rsp_data, bank_err,
        input  sram_en, sram_we, sram_addr, sram_wdata, dbg_rr_ptr
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata, sram_rdata,
        output req_ready, rsp_valid, rsp_data, bank_err,
        output sram_en, sram_we, sram_addr, sram_wdata, dbg_rr_ptr
    );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbiter sharing multi_sram banks among requesters, with a
// fixed-latency read-return pipeline that routes bank data back to the issuing requester.
module sram_bank_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_SRAMS    = 4,
    parameter int BANK_W       = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int SRAM_LATENCY = 1
) (
    input logic                clk,
    input logic                rst,
    sram_bank_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT   = SRAM_LATENCY;

    logic [NUM_SRAMS-1:0][PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [LAT-1:0][NUM_REQ-1:0]             pipe_vld_q, pipe_vld_d;
    logic [LAT-1:0][NUM_REQ-1:0]             pipe_oor_q, pipe_oor_d;
    logic [LAT-1:0][NUM_REQ-1:0][BANK_W-1:0] pipe_bank_q, pipe_bank_d;
    logic                                    bank_err_q, bank_err_d;

    logic [NUM_REQ-1:0][BANK_W-1:0]  req_bank_f;
    logic [NUM_REQ-1:0]              req_oor;
    logic [NUM_SRAMS-1:0]            gnt_vld;
    logic [NUM_SRAMS-1:0][PTR_W-1:0] gnt_id;
    logic [NUM_REQ-1:0]              ready;

    logic [NUM_SRAMS-1:0]            sram_en_c;
    logic [NUM_SRAMS-1:0]            sram_we_c;
    logic [NUM_SRAMS*ADDR_WIDTH-1:0] sram_addr_c;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_wdata_c;
    logic [NUM_REQ-1:0]              rsp_valid_c;
    logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_data_c;

    function automatic int rr_idx(input int ptr, input int step);
        int s;
        s = ptr + step;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    always_comb begin
        req_bank_f = '0;
        req_oor    = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_bank_f[r] = bus.req_bank[r*BANK_W +: BANK_W];
            req_oor[r]    = bus.req_valid[r] && (int'(req_bank_f[r]) >= NUM_SRAMS);
        end
    end

    // Out-of-range banks never match b below, so they stay out of the per-bank race.
    always_comb begin
        gnt_vld = '0;
        gnt_id  = '0;
        ready   = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_vld[b] && bus.req_valid[rr_idx(int'(rr_ptr_q[b]), k)] &&
                    (req_bank_f[rr_idx(int'(rr_ptr_q[b]), k)] == BANK_W'(b))) begin
                    gnt_vld[b] = 1'b1;
                    gnt_id[b]  = PTR_W'(rr_idx(int'(rr_ptr_q[b]), k));
                end
            end
        end
        if (rst) begin
            gnt_vld = '0;
        end
        for (int b = 0; b < NUM_SRAMS; b++) begin
            if (gnt_vld[b]) begin
                ready[gnt_id[b]] = 1'b1;
            end
        end
        if (!rst) begin
            ready = ready | req_oor;
        end
    end

    always_comb begin
        sram_en_c    = '0;
        sram_we_c    = '0;
        sram_addr_c  = '0;
        sram_wdata_c = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            if (gnt_vld[b]) begin
                sram_en_c[b] = 1'b1;
                sram_we_c[b] = bus.req_we[gnt_id[b]];
                sram_addr_c[b*ADDR_WIDTH +: ADDR_WIDTH] =
                    bus.req_addr[int'(gnt_id[b])*ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdata_c[b*DATA_WIDTH +: DATA_WIDTH] =
                    bus.req_wdata[int'(gnt_id[b])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            if (gnt_vld[b]) begin
                rr_ptr_d[b] = PTR_W'(rr_idx(int'(gnt_id[b]), 1));
            end
        end
        bank_err_d = bank_err_q | (|req_oor);
    end

    // Stage 0 captures every read accepted this cycle; the requester id is the lane index.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_oor_d     = pipe_oor_q;
        pipe_bank_d    = pipe_bank_q;
        pipe_vld_d[0]  = ready & ~bus.req_we;
        pipe_oor_d[0]  = req_oor;
        pipe_bank_d[0] = req_bank_f;
        for (int s = 1; s < LAT; s++) begin
            pipe_vld_d[s]  = pipe_vld_q[s-1];
            pipe_oor_d[s]  = pipe_oor_q[s-1];
            pipe_bank_d[s] = pipe_bank_q[s-1];
        end
    end

    always_comb begin
        rsp_valid_c = '0;
        rsp_data_c  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_valid_c[r] = pipe_vld_q[LAT-1][r] && !rst;
            if (rsp_valid_c[r] && !pipe_oor_q[LAT-1][r]) begin
                rsp_data_c[r*DATA_WIDTH +: DATA_WIDTH] =
                    bus.sram_rdata[int'(pipe_bank_q[LAT-1][r])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            pipe_vld_q  <= '0;
            pipe_oor_q  <= '0;
            pipe_bank_q <= '0;
            bank_err_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_oor_q  <= pipe_oor_d;
            pipe_bank_q <= pipe_bank_d;
            bank_err_q  <= bank_err_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.sram_en    = sram_en_c;
    assign bus.sram_we    = sram_we_c;
    assign bus.sram_addr  = sram_addr_c;
    assign bus.sram_wdata = sram_wdata_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_data   = rsp_data_c;
    assign bus.bank_err   = bank_err_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench: four arbiter configurations (banks/latency) share one stimulus stream,
// each with its own behavioural multi_sram; checks are immediate assertions.
module tb_sram_bank_arbiter;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_we;
    logic [NR*BW-1:0] req_bank;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;

    logic [3:0][3:0]  rdy, rsp_v, en_a, we_a;
    logic [3:0][63:0] rsp_d, addr_a, wd_a;
    logic [3:0][7:0]  dbg;
    logic [3:0]       err;

    int lat_of [4] = '{1, 1, 2, 4};
    int n_assert = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    // Config 0: 4 banks lat 1; 1: 3 banks lat 1; 2: 4 banks lat 2; 3: 4 banks lat 4
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NS  = (g == 1) ? 3 : 4;
        localparam int LAT = (g == 3) ? 4 : ((g == 2) ? 2 : 1);

        sram_bank_arbiter_if #(.NUM_REQ(NR), .NUM_SRAMS(NS), .BANK_W(BW),
                               .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        sram_bank_arbiter #(.NUM_REQ(NR), .NUM_SRAMS(NS), .BANK_W(BW), .ADDR_WIDTH(AW),
                            .DATA_WIDTH(DW), .SRAM_LATENCY(LAT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.req_valid = req_valid;
        assign bus.req_we    = req_we;
        assign bus.req_bank  = req_bank;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign rdy[g]    = bus.req_ready;
        assign rsp_v[g]  = bus.rsp_valid;
        assign rsp_d[g]  = bus.rsp_data;
        assign err[g]    = bus.bank_err;
        assign en_a[g]   = 4'(bus.sram_en);
        assign we_a[g]   = 4'(bus.sram_we);
        assign addr_a[g] = 64'(bus.sram_addr);
        assign wd_a[g]   = 64'(bus.sram_wdata);
        assign dbg[g]    = 8'(bus.dbg_rr_ptr);

        logic [DW-1:0]    mem [NS][64];
        logic [NS*DW-1:0] rd_pipe [LAT];

        always @(posedge clk) begin
            for (int b = 0; b < NS; b++) begin
                if (bus.sram_en[b]) begin
                    if (bus.sram_we[b])
                        mem[b][bus.sram_addr[b*AW +: 6]] <= bus.sram_wdata[b*DW +: DW];
                    else
                        rd_pipe[0][b*DW +: DW] <= mem[b][bus.sram_addr[b*AW +: 6]];
                end
            end
            for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
        end
        assign bus.sram_rdata = rd_pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_bank  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int r, input logic w, input logic [1:0] b,
                           input logic [15:0] a, input logic [15:0] d);
        req_valid[r]         = 1'b1;
        req_we[r]            = w;
        req_bank[r*BW +: BW] = b;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    // Requester rule: an unaccepted request stays valid with unchanged fields next cycle.
    logic [NR-1:0] pend = '0;
    logic [NR-1:0][35:0] pend_fields;
    always @(negedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NR; r++) begin
                if (pend[r])
                    chk("req_hold", {req_valid[r], req_we[r], req_bank[r*BW +: BW],
                        req_addr[r*AW +: AW], req_wdata[r*DW +: DW]}, 64'(pend_fields[r]));
            end
        end
        pend <= rst ? '0 : (req_valid & ~rdy[0]);
        for (int r = 0; r < NR; r++)
            pend_fields[r] <= {1'b1, req_we[r], req_bank[r*BW +: BW],
                               req_addr[r*AW +: AW], req_wdata[r*DW +: DW]};
    end

    int n_pulse [4];
    int g;

    initial begin
        rst = 1'b1;
        clear_reqs();
        n_pulse = '{0, 0, 0, 0};

        // Reset: everything quiet even with requests pending
        tick();
        req_valid = 4'hF;
        #1;
        chk("rst_ready", rdy[0], 64'h0);
        chk("rst_en", {en_a[3], en_a[0]}, 64'h0);
        chk("rst_addr_wdata", addr_a[0] | wd_a[0], 64'h0);
        chk("rst_rsp", rsp_v[0], 64'h0);
        tick();
        clear_reqs();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ptr", dbg[0], 64'h0);
        chk("rst_err", err[1], 64'h0);

        // Single read: GEMM1 writes bank1/0x10, ELEM reads it back
        tick();
        set_req(0, 1'b1, 2'd1, 16'h0010, 16'h1234);
        #1;
        chk("t1_wr_ready", rdy[0], 64'b0001);
        chk("t1_wr_en", en_a[0], 64'b0010);
        chk("t1_wr_we", we_a[0], 64'b0010);
        chk("t1_wr_addr", addr_a[0], 64'h0000_0000_0010_0000);
        chk("t1_wr_data", wd_a[0], 64'h0000_0000_1234_0000);
        tick();
        clear_reqs();
        set_req(2, 1'b0, 2'd1, 16'h0010, 16'h0000);
        #1;
        chk("t1_rd_ready", rdy[0], 64'b0100);
        chk("t1_rd_we", we_a[0], 64'h0);
        tick();
        clear_reqs();
        #1;
        chk("t1_rsp_v", rsp_v[0], 64'b0100);
        chk("t1_rsp_d", rsp_d[0], 64'h0000_1234_0000_0000);
        chk("t1_lat2_early", rsp_v[2], 64'h0);
        tick();
        #1;
        chk("t1_pulse_end", rsp_v[0], 64'h0);
        chk("t1_lat2_v", rsp_v[2], 64'b0100);
        chk("t1_lat2_d", rsp_d[2], 64'h0000_1234_0000_0000);
        tick();
        #1;
        chk("t1_lat4_early", rsp_v[3], 64'h0);
        tick();
        #1;
        chk("t1_lat4_v", rsp_v[3], 64'b0100);
        chk("t1_lat4_d", rsp_d[3], 64'h0000_1234_0000_0000);

        // Round-robin: all four hold writes on bank 0
        tick();
        clear_reqs();
        for (int r = 0; r < NR; r++)
            set_req(r, 1'b1, 2'd0, 16'h0020 + 16'(r), 16'h0A00 + 16'(r));
        #1;
        chk("t2_gnt0", rdy[0], 64'b0001);
        chk("t2_addr0", addr_a[0], 64'h0020);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("t2_gnt1", rdy[0], 64'b0010);
        chk("t2_addr1", addr_a[0], 64'h0021);
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("t2_gnt2", rdy[0], 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        #1;
        chk("t2_gnt3", rdy[0], 64'b1000);
        chk("t2_wdata3", wd_a[0], 64'h0A03);
        tick();
        clear_reqs();
        #1;
        chk("t2_ptrs", dbg[0], 64'h0C);

        // Parallel banks: bank0 and bank2 written together, then cross read-back
        tick();
        set_req(0, 1'b1, 2'd0, 16'h0005, 16'h00AA);
        set_req(1, 1'b1, 2'd2, 16'h0005, 16'h00BB);
        #1;
        chk("t3_wr_ready", rdy[0], 64'b0011);
        chk("t3_wr_en", en_a[0], 64'b0101);
        chk("t3_wr_we", we_a[0], 64'b0101);
        chk("t3_wr_addr", addr_a[0], 64'h0000_0005_0000_0005);
        chk("t3_wr_data", wd_a[0], 64'h0000_00BB_0000_00AA);
        tick();
        clear_reqs();
        set_req(0, 1'b0, 2'd2, 16'h0005, 16'h0000);
        set_req(1, 1'b0, 2'd0, 16'h0005, 16'h0000);
        #1;
        chk("t3_rd_ready", rdy[0], 64'b0011);
        chk("t3_rd_en", en_a[0], 64'b0101);
        tick();
        clear_reqs();
        #1;
        chk("t3_rsp_v", rsp_v[0], 64'b0011);
        chk("t3_rsp_d", rsp_d[0], 64'h0000_0000_00AA_00BB);
        chk("t3_ptrs", dbg[0], 64'h1E);

        // Out-of-range bank on the 3-bank configuration
        tick();
        set_req(3, 1'b0, 2'd3, 16'h0007, 16'h0000);
        #1;
        chk("t4_ready", rdy[1], 64'b1000);
        chk("t4_no_en", en_a[1], 64'h0);
        chk("t4_err_pre", err[1], 64'h0);
        tick();
        clear_reqs();
        #1;
        chk("t4_rsp_v", rsp_v[1], 64'b1000);
        chk("t4_rsp_d", rsp_d[1], 64'h0);
        chk("t4_err", err[1], 64'h1);
        chk("t4_err_inrange", err[0], 64'h0);
        chk("t4_ptr_kept", dbg[1], 64'h1E);
        tick();
        set_req(0, 1'b1, 2'd0, 16'h0009, 16'h1111);
        set_req(3, 1'b1, 2'd3, 16'h0009, 16'h2222);
        #1;
        chk("t4_nocompete_ready", rdy[1], 64'b1001);
        chk("t4_nocompete_en", en_a[1], 64'b0001);
        tick();
        clear_reqs();
        #1;
        chk("t4_err_sticky", err[1], 64'h1);
        chk("t4_wr_no_rsp", rsp_v[1], 64'h0);
        chk("t4_ptrs", dbg[1], 64'h1D);

        // Reset one cycle after a read is accepted
        tick();
        set_req(1, 1'b0, 2'd2, 16'h0005, 16'h0000);
        #1;
        chk("t5_ready", rdy[2], 64'b0010);
        tick();
        clear_reqs();
        rst = 1'b1;
        #1;
        chk("t5_rsp_in_rst", {rsp_v[3], rsp_v[2], rsp_v[1], rsp_v[0]}, 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_no_rsp", rsp_v[2], 64'h0);
        chk("t5_ptrs", {dbg[3], dbg[2], dbg[1], dbg[0]}, 64'h0);
        chk("t5_err_clr", err[1], 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("t5_quiet", {rsp_v[3], rsp_v[2], rsp_v[1], rsp_v[0]}, 64'h0);
        end

        // Latency sweep: ELEM fills bank1 then reads 8 words back-to-back
        for (int i = 0; i < 8; i++) begin
            tick();
            clear_reqs();
            set_req(2, 1'b1, 2'd1, 16'(i), 16'h5A00 + 16'(i) * 16'h0111);
            #1;
            chk("t6_wr_ready", rdy[0], 64'b0100);
            chk("t6_wr_no_rsp", {rsp_v[3], rsp_v[2], rsp_v[0]}, 64'h0);
        end
        for (int t = 0; t < 13; t++) begin
            tick();
            clear_reqs();
            if (t < 8) begin
                set_req(2, 1'b0, 2'd1, 16'(t), 16'h0000);
                exp_q.push_back(16'h5A00 + 16'(t) * 16'h0111);
            end
            #1;
            if (t < 8) chk("t6_rd_ready", rdy[0], 64'b0100);
            for (int gi = 0; gi < 3; gi++) begin
                g = (gi == 0) ? 0 : gi + 1;
                if (rsp_v[g][2]) n_pulse[g]++;
                if (t >= lat_of[g] && t - lat_of[g] < 8) begin
                    chk("t6_rsp_v", rsp_v[g], 64'b0100);
                    chk("t6_rsp_d", rsp_d[g][47:32], 64'(exp_q[t - lat_of[g]]));
                end else begin
                    chk("t6_idle", rsp_v[g], 64'h0);
                end
            end
        end
        chk("t6_pulses_l1", n_pulse[0], 64'd8);
        chk("t6_pulses_l2", n_pulse[2], 64'd8);
        chk("t6_pulses_l4", n_pulse[3], 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
